button_event_decoder: RTL
=========================

// Module: button_event_decoder
// PURPOSE
//  Downstream stage of the per-button debouncer. Turns each debounced level into one-cycle event
//  pulses: press, release, long-press and auto-repeat, plus a registered "held" level.
//  Feeds the user-I/O FSMs, which consume single-cycle pulses only and never raw levels.
//  All channels share one free-running tick prescaler, so every hold time is counted in ticks.
// PARAMETERS
//  width             1       number of independent button channels
//  tick_count_max    125000  clk cycles per tick (1 ms @ 125 MHz); must be >= 1
//  long_press_ticks  500     ticks held after press before long_press fires; must be >= 1
//  repeat_ticks      100     ticks between repeat pulses once in HELD; must be >= 1
//  tick_cnt_width    `log2(tick_count_max)  prescaler width (derived)
//  hold_cnt_width    `log2(max(long_press_ticks,repeat_ticks))  per-channel counter width (derived)
// PORTS
//  clk               in   1      system clock
//  rst_n             in   1      asynchronous active-low reset
//  debounced_signal  in   width  synchronized, debounced button levels
//  press             out  width  1-cycle pulse on rising level
//  release           out  width  1-cycle pulse on falling level
//  long_press        out  width  1-cycle pulse when hold reaches long_press_ticks
//  repeat            out  width  1-cycle pulse every repeat_ticks while in HELD
//  held              out  width  level: channel state != IDLE
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
//  - Reset (async assert, sync release): prescaler=0, tick=0; every channel state=IDLE, prev=0,
//    counter=0; all outputs 0.
//  - Prescaler: counts 0..tick_count_max-1, then wraps. tick=1 for the one cycle when count==max-1.
//    tick_count_max=1 gives tick=1 every cycle.
//  - Per channel: prev<=d each cycle; rise = d & ~prev; fall = ~d & prev.
//  - All outputs are registered. An event detected in cycle k shows on its output in cycle k+1.
//    Input change in cycle k -> press/release high in cycle k+1 only.
//  - FSM states IDLE, PRESSED, HELD. Per-channel counter counts ticks.
//    IDLE:    rise -> press, PRESSED, counter=0.
//    PRESSED: tick -> counter++; if counter==long_press_ticks-1 on a tick -> long_press, HELD, counter=0.
//    HELD:    tick -> counter++; if counter==repeat_ticks-1 on a tick -> repeat, counter=0.
//    PRESSED/HELD: fall -> release, IDLE, counter=0.
//  - The press cycle's tick is not counted. long_press lands (long_press_ticks-1)*T+1 ..
//    long_press_ticks*T cycles after the press pulse, where T=tick_count_max.
//  - Simultaneous fall and tick expiry: release wins. No long_press or repeat that cycle.
//  - rise while not IDLE cannot occur (prev tracks d); no action is defined for it.
//  - Input high when reset releases: press fires in the 2nd cycle after release (prev reset 0).
//  - Counter never exceeds its target-1; no wrap or overflow path exists.
//  - held is high from the press-pulse cycle through the cycle before the release pulse.
//  - At most one of press/release/long_press/repeat is high per channel per cycle.
//  - Channels are fully independent apart from the shared tick.
// STRUCTURE
//  - `log2 comes from util.vh. Put the state encoding as localparams (IDLE=2'd0, PRESSED=2'd1,
//    HELD=2'd2) in shared header button_defs.vh; the user-I/O FSMs reuse it.
//  - Top: prescaler plus a generate loop of width x button_event_channel.
//  - button_event_channel: one FSM, counter, prev reg and 4 output regs; ports clk, rst_n, tick, d,
//    and the 4 pulses plus held.
// TESTING  (width=2, tick_count_max=4, long_press_ticks=3, repeat_ticks=2 unless noted)
//  1 Short tap: ch0 high 5 cycles -> press 1 cycle at k+1, release 1 cycle; no long_press;
//    held high exactly 5 cycles.
//  2 Long hold: ch0 high 40 cycles -> long_press once 9..12 cycles after press, then repeat
//    every 8 cycles; no repeat after release.
//  3 Collision: drop ch0 in the exact cycle its long_press tick expires -> release only,
//    long_press never fires.
//  4 Reset mid-hold: assert rst_n=0 while ch1 is HELD -> all outputs 0 asynchronously.
//    Input still high at release -> press in 2nd cycle, then full long-press timing.
//  5 Independence: ch0 and ch1 pressed 3 cycles apart -> distinct pulse streams; ch1 release
//    leaves ch0 repeat cadence intact.
//  6 tick_count_max=1, long_press_ticks=1 -> long_press in the cycle directly after press;
//    one-hot pulse check every cycle.

Source files
------------

// File: rtl/button_event_decoder_pkg.sv
//==============================================================================
// button_event_decoder_pkg: channel state encoding and width helpers.
// Revision: 1.0
//==============================================================================
`default_nettype none

package button_event_decoder_pkg;

    typedef logic [1:0] btn_state_t;

    // Encoding is shared with the user-I/O FSMs.
    localparam btn_state_t IDLE    = 2'd0;
    localparam btn_state_t PRESSED = 2'd1;
    localparam btn_state_t HELD    = 2'd2;

    function automatic int cnt_width(input int n_values);
        return (n_values <= 1) ? 1 : $clog2(n_values);
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/button_event_channel.sv
//==============================================================================
// button_event_channel: one button's edge detector, hold FSM and event pulses.
// Revision: 1.0
//==============================================================================
`default_nettype none

module button_event_channel
    import button_event_decoder_pkg::*;
#(
    parameter int LONG_PRESS_TICKS = 500,
    parameter int REPEAT_TICKS     = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic d,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    localparam int CNT_W = cnt_width(max_of(LONG_PRESS_TICKS, REPEAT_TICKS));
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS_TICKS - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_TICKS - 1);

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_press_q, long_press_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;

    logic rise;
    logic fall;

    assign rise = d & ~prev_q;
    assign fall = ~d & prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            prev_q       <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_press_q <= 1'b0;
            repeat_q     <= 1'b0;
            held_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prev_q       <= d;
            press_q      <= press_d;
            release_q    <= release_d;
            long_press_q <= long_press_d;
            repeat_q     <= repeat_d;
            held_q       <= held_d;
        end
    end

    // A falling level always takes priority over a tick expiring in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == LP_LAST) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HELD: begin
                if (fall) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == RP_LAST) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        press_d      = 1'b0;
        release_d    = 1'b0;
        long_press_d = 1'b0;
        repeat_d     = 1'b0;
        held_d       = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                press_d = rise;
            end
            PRESSED: begin
                release_d    = fall;
                long_press_d = ~fall & tick & (cnt_q == LP_LAST);
            end
            HELD: begin
                release_d = fall;
                repeat_d  = ~fall & tick & (cnt_q == RP_LAST);
            end
            default: ;
        endcase
    end

    assign press         = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_press_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;

endmodule

`default_nettype wire

// File: rtl/button_event_decoder.sv
//==============================================================================
// button_event_decoder: shared tick prescaler feeding WIDTH event channels.
// release/repeat are SystemVerilog keywords, hence the _pulse port names.
// Revision: 1.0
//==============================================================================
`default_nettype none

module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int WIDTH            = 1,
    parameter int TICK_COUNT_MAX   = 125000,
    parameter int LONG_PRESS_TICKS = 500,
    parameter int REPEAT_TICKS     = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] long_press,
    output logic [WIDTH-1:0] repeat_pulse,
    output logic [WIDTH-1:0] held
);

    localparam int TICK_W = cnt_width(TICK_COUNT_MAX);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_COUNT_MAX - 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick_q, tick_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
        end
    end

    // tick is registered from the next count so it aligns with count == max-1.
    always_comb begin
        if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
        tick_d = (tick_cnt_d == TICK_LAST);
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_channel
            button_event_channel #(
                .LONG_PRESS_TICKS (LONG_PRESS_TICKS),
                .REPEAT_TICKS     (REPEAT_TICKS)
            ) u_channel (
                .clk           (clk),
                .rst_n         (rst_n),
                .tick          (tick_q),
                .d             (debounced_signal[i]),
                .press         (press[i]),
                .release_pulse (release_pulse[i]),
                .long_press    (long_press[i]),
                .repeat_pulse  (repeat_pulse[i]),
                .held          (held[i])
            );
        end
    endgenerate

endmodule

`default_nettype wire
